// File: rtl/riscv_pkg.sv
// Shared RV32IM pipeline definitions: bubble word, reset PC, fetch FSM encoding,
// IF/ID payload types and the base opcodes used by decode.
package riscv_pkg;

    localparam logic [31:0] RV_NOP_INSTR = 32'h0000_0013;
    localparam logic [31:0] RV_RESET_PC  = 32'h0000_0000;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_HOLD,
        S_DISCARD
    } fetch_state_e;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc4;
    } fetch_word_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic        valid;
    } if_id_t;

    function automatic logic [31:0] align_pc(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

    function automatic logic is_rv32_opcode(input logic [6:0] opc);
        logic hit;
        hit = 1'b0;
        case (opc)
            OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH,
            OPC_LOAD, OPC_STORE, OPC_OP_IMM, OPC_OP: hit = 1'b1;
            default: hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/if_id_pipeline_reg.sv
// IF/ID pipeline register: 97-bit {instruction, pc, pc4, valid} with load,
// bubble and hold controls; a bubble keeps the previous pc/pc4.
module if_id_pipeline_reg
    import riscv_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = RV_NOP_INSTR
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        load_i,
    input  logic        bubble_i,
    input  logic [31:0] instr_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] pc4_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    output logic [31:0] pc4_o,
    output logic        valid_o
);

    if_id_t if_id_q;
    if_id_t if_id_d;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        if_id_d = if_id_q;
        if (bubble_i) begin
            if_id_d.instr = NOP_INSTR;
            if_id_d.valid = 1'b0;
        end else if (load_i) begin
            if_id_d = '{instr: instr_i, pc: pc_i, pc4: pc4_i, valid: 1'b1};
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            if_id_q <= '{instr: NOP_INSTR, pc: 32'h0, pc4: 32'h0, valid: 1'b0};
        end else begin
            if_id_q <= if_id_d;
        end
    end

    assign instr_o = if_id_q.instr;
    assign pc_o    = if_id_q.pc;
    assign pc4_o   = if_id_q.pc4;
    assign valid_o = if_id_q.valid;

endmodule

// File: rtl/instruction_fetch_unit.sv
// IF stage: PC, instruction-memory handshake, stall/redirect handling, IF/ID load.
// Optional IF_PERF_COUNTERS_EN adds fetch_count and bubble_count outputs.
module instruction_fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RV_RESET_PC,
    parameter logic [31:0] NOP_INSTR = RV_NOP_INSTR
) (
    input  logic        CLK,
    input  logic        RESET,
    output logic        imem_read,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_readdata,
    input  logic        imem_busywait,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_target,
    output logic [31:0] if_id_instruction,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_pc4,
    output logic        if_id_valid
`ifdef IF_PERF_COUNTERS_EN
    ,
    output logic [31:0] fetch_count,
    output logic [31:0] bubble_count
`endif
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  pending_pc_q, pending_pc_d;
    fetch_word_t  skid_q, skid_d;

    logic [31:0]  pc_plus4;
    logic [31:0]  target_aligned;
    fetch_word_t  fetched;
    fetch_word_t  load_word;
    logic         ifid_load;
    logic         ifid_bubble;

    assign pc_plus4       = pc_q + 32'd4;
    assign target_aligned = align_pc(redirect_target);
    assign fetched        = '{instr: imem_readdata, pc: pc_q, pc4: pc_plus4};
    assign imem_addr      = pc_q;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        pending_pc_d = pending_pc_q;
        skid_d       = skid_q;
        imem_read    = 1'b0;
        ifid_load    = 1'b0;
        ifid_bubble  = 1'b0;
        load_word    = fetched;

        case (state_q)
            S_IDLE: begin
                state_d = S_REQ;
            end

            S_REQ: begin
                imem_read = 1'b1;
                if (redirect && imem_busywait) begin
                    // The read in flight cannot be cancelled; park the target until it drains.
                    pending_pc_d = target_aligned;
                    ifid_bubble  = 1'b1;
                    state_d      = S_DISCARD;
                end else if (redirect) begin
                    pc_d        = target_aligned;
                    ifid_bubble = 1'b1;
                end else if (imem_busywait) begin
                    ifid_bubble = !stall;
                end else if (!stall) begin
                    ifid_load = 1'b1;
                    pc_d      = pc_plus4;
                end else begin
                    skid_d  = fetched;
                    pc_d    = pc_plus4;
                    state_d = S_HOLD;
                end
            end

            S_HOLD: begin
                if (redirect) begin
                    pc_d        = target_aligned;
                    ifid_bubble = 1'b1;
                    state_d     = S_REQ;
                end else if (!stall) begin
                    ifid_load = 1'b1;
                    load_word = skid_q;
                    state_d   = S_REQ;
                end
            end

            S_DISCARD: begin
                imem_read   = 1'b1;
                ifid_bubble = !stall;
                if (redirect) begin
                    pending_pc_d = target_aligned;
                end
                if (!imem_busywait) begin
                    pc_d    = redirect ? target_aligned : pending_pc_q;
                    state_d = S_REQ;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q      <= S_IDLE;
            pc_q         <= RESET_PC;
            pending_pc_q <= 32'h0;
            skid_q       <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            pending_pc_q <= pending_pc_d;
            skid_q       <= skid_d;
        end
    end

    if_id_pipeline_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id (
        .clk_i    (CLK),
        .rst_ni   (RESET),
        .load_i   (ifid_load),
        .bubble_i (ifid_bubble),
        .instr_i  (load_word.instr),
        .pc_i     (load_word.pc),
        .pc4_i    (load_word.pc4),
        .instr_o  (if_id_instruction),
        .pc_o     (if_id_pc),
        .pc4_o    (if_id_pc4),
        .valid_o  (if_id_valid)
    );

`ifdef IF_PERF_COUNTERS_EN
    logic [31:0] fetch_count_q, fetch_count_d;
    logic [31:0] bubble_count_q, bubble_count_d;

    always_comb begin
        fetch_count_d  = fetch_count_q;
        bubble_count_d = bubble_count_q;
        if (ifid_bubble) begin
            bubble_count_d = bubble_count_q + 32'd1;
        end else if (ifid_load) begin
            fetch_count_d = fetch_count_q + 32'd1;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            fetch_count_q  <= 32'h0;
            bubble_count_q <= 32'h0;
        end else begin
            fetch_count_q  <= fetch_count_d;
            bubble_count_q <= bubble_count_d;
        end
    end

    assign fetch_count  = fetch_count_q;
    assign bubble_count = bubble_count_q;
`endif

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- IF stage of the 5-stage RV32IM pipeline: owns the PC, issues reads to instruction memory and honours its busywait handshake.
- Loads the IF/ID pipeline register, whose instruction output drives the control unit's Instruction input.
- Handles downstream stall (hazard unit) and redirect (branch/jump resolved in EX), including redirects that arrive while a memory read is in flight.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
NOP_INSTR, 32'h0000_0013, bubble word (ADDI x0,x0,0) placed in IF/ID on flush or empty fetch

Ports:
CLK  input  1  pipeline clock, rising-edge
RESET  input  1  asynchronous, active-low reset
imem_read  output  1  instruction memory read request
imem_addr  output  32  instruction memory byte address
imem_readdata  input  32  instruction word, valid when imem_read=1 and imem_busywait=0 at the CLK edge
imem_busywait  input  1  memory not ready; hold request
stall  input  1  hazard unit: hold IF/ID and PC
redirect  input  1  branch taken or jump, from EX
redirect_target  input  32  new PC; bits [1:0] forced to 0 internally
if_id_instruction  output  32  registered instruction to decode/control unit
if_id_pc  output  32  PC of if_id_instruction
if_id_pc4  output  32  PC+4 of if_id_instruction, used for JAL/JALR writeback
if_id_valid  output  1  1 = real instruction, 0 = bubble

Behaviour:
- Interface: one clock, CLK; RESET is asynchronous and active-low. On RESET=0:
  - pc=RESET_PC, state=S_IDLE.
  - if_id_instruction=NOP_INSTR, if_id_pc=0, if_id_pc4=0, if_id_valid=0.
  - imem_read=0, skid and pending registers cleared.
- S_IDLE: exactly one cycle after reset deassertion, imem_read=0, then go to S_REQ.
- S_REQ (imem_read=1, imem_addr=pc). Per edge, first match wins:
  1. redirect=1 and busywait=1: latch the aligned target into pending_pc. Go to S_DISCARD. IF/ID gets a bubble.
  2. redirect=1 and busywait=0: drop the fetched word. pc<=target. IF/ID gets a bubble. Stay in S_REQ. Redirect beats stall.
  3. busywait=1: pc held. If stall=0, IF/ID gets a bubble; else IF/ID held.
  4. busywait=0, stall=0: IF/ID <= {readdata, pc, pc+4, 1}. pc<=pc+4.
  5. busywait=0, stall=1: IF/ID held. skid<={readdata, pc, pc+4}. pc<=pc+4. Go to S_HOLD.
- S_HOLD (imem_read=0):
  - redirect=1: drop skid, pc<=target, IF/ID gets a bubble, go to S_REQ.
  - stall=0: IF/ID <= {skid, 1}, go to S_REQ.
  - Otherwise hold everything.
- S_DISCARD (imem_read=1, imem_addr=old pc, unchanged):
  - A further redirect overwrites pending_pc.
  - When busywait=0: drop the returned word, pc<=pending_pc (latest), go to S_REQ.
  - IF/ID gets a bubble every cycle while stall=0, else held.
- Latency: on a zero-wait memory, an instruction reaches IF/ID 1 edge after its address is presented. Throughput is 1 instruction/cycle.
- pc+4 wraps modulo 2^32: 32'hFFFF_FFFC gives 32'h0000_0000.
- "Bubble" means if_id_instruction=NOP_INSTR, if_id_valid=0, if_id_pc and if_id_pc4 unchanged.
- imem_addr is stable whenever busywait=1. It changes only on the edge where the read completes or on a redirect with busywait=0.
- Reset asserted mid-read or mid-discard: return immediately to reset values. Any in-flight word is ignored.

Optional Feature:
- IF_PERF_COUNTERS_EN defined:
  - Adds output fetch_count (32): increments on each edge where IF/ID loads with valid=1.
  - Adds output bubble_count (32): increments on each edge where IF/ID loads a bubble.
  - Both counters wrap, and reset to 0.
- Not defined: neither port nor the counter logic exists.

Decomposition:
- Shared package riscv_pkg:
  - NOP_INSTR constant and RESET_PC default.
  - Fetch FSM state encoding: S_IDLE, S_REQ, S_HOLD, S_DISCARD.
  - Opcode constants already used by decode.
- One sub-module, if_id_pipeline_reg: a 97-bit register {instruction, pc, pc4, valid} with async active-low reset and load/bubble/hold controls. The FSM and PC logic stay in instruction_fetch_unit.

Test Plan:
- Reset release, zero-wait memory returning addr-based words -> IF/ID pc sequence 0,4,8,12 on consecutive edges, valid=1, pc4=pc+4, imem_read low for one cycle after reset.
- busywait held high 3 cycles at pc=8, stall=0 -> imem_addr stays 8, three bubbles (instr=32'h13, valid=0), then pc=8 loaded.
- stall=1 for 2 cycles while word at pc=4 returns -> IF/ID holds pc=0, imem_read=0 during S_HOLD; on stall release IF/ID gets pc=4 word, next fetch addr=8.
- redirect=1, target=32'h100 while busywait=1 at pc=12 -> addr stays 12 until busywait falls; word discarded, next imem_addr=32'h100, no valid IF/ID entry for pc=12.
- redirect with target=32'h203 and stall=1 simultaneously -> IF/ID bubble, next imem_addr=32'h200.
- pc=32'hFFFF_FFFC fetch completes -> if_id_pc4=0, next imem_addr=0; with IF_PERF_COUNTERS_EN, fetch_count increments per valid load, bubble_count per bubble.
